// File: rtl/clock_phase_gen_pkg.sv
// Shared types and defaults for the clock phase generator.
// FSM encoding plus a width helper used to size the phase and hold counters.
package clock_phase_gen_pkg;

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      RUN     = 2'd1,
      STOPPED = 2'd2,
      STEP    = 2'd3
   } fsm_t;

   localparam int PROC_DIV_DEF   = 4;
   localparam int RESET_HOLD_DEF = 2;

   // Counter width for a modulo-n count; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/clock_phase_gen_phase_counter.sv
// Free-running modulo-MOD phase counter with a wrap strobe.
// Exposes the next count so callers can register decodes of it.
module phase_counter
   import clock_phase_gen_pkg::*;
#(
   parameter int MOD = PROC_DIV_DEF,
   parameter int W   = cnt_w(MOD)
) (
   input  logic         clock,
   input  logic         reset,
   output logic [W-1:0] cnt_next,
   output logic         wrap
);

   logic [W-1:0] cnt;

   assign wrap     = (cnt == W'(MOD - 1));
   assign cnt_next = wrap ? '0 : cnt + W'(1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) cnt <= '0;
      else       cnt <= cnt_next;
   end

endmodule

// File: rtl/clock_phase_gen.sv
// Derives imem/dmem/processor/regfile clocks and a stretched core reset
// from the board clock, with debug stop and single-step gating.
module clock_phase_gen
   import clock_phase_gen_pkg::*;
#(
   parameter int PROC_DIV   = PROC_DIV_DEF,
   parameter int RESET_HOLD = RESET_HOLD_DEF,
   parameter int CNT_W      = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             stop_req,
   input  logic             step,
   output logic             imem_clock,
   output logic             dmem_clock,
   output logic             processor_clock,
   output logic             regfile_clock,
   output logic             core_reset,
   output logic             stopped,
   output logic [CNT_W-1:0] cycle_count
);

   localparam int PW = cnt_w(PROC_DIV);
   localparam int HW = cnt_w(RESET_HOLD);
   localparam logic [PW-1:0] HALF = PW'(PROC_DIV / 2);

   fsm_t          state;
   fsm_t          state_next;
   logic [HW-1:0] hold_cnt;
   logic          step_pending;
   logic [PW-1:0] cnt_next;
   logic          wrap;

   phase_counter #(
      .MOD (PROC_DIV),
      .W   (PW)
   ) u_phase (
      .clock    (clock),
      .reset    (reset),
      .cnt_next (cnt_next),
      .wrap     (wrap)
   );

   always_comb begin
      state_next = state;
      if (wrap) begin
         unique case (state)
            HOLD:
               if (hold_cnt == HW'(RESET_HOLD - 1)) state_next = RUN;
            RUN:
               if (stop_req) state_next = STOPPED;
            STOPPED:
               if (step_pending)  state_next = STEP;
               else if (!stop_req) state_next = RUN;
            STEP:
               state_next = stop_req ? STOPPED : RUN;
            default:
               state_next = HOLD;
         endcase
      end
   end

   // Outputs are decoded from the next state so gating lands on the wrap edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state           <= HOLD;
         hold_cnt        <= '0;
         step_pending    <= 1'b0;
         imem_clock      <= 1'b0;
         dmem_clock      <= 1'b1;
         processor_clock <= 1'b0;
         core_reset      <= 1'b1;
         stopped         <= 1'b0;
         cycle_count     <= '0;
      end else begin
         state           <= state_next;
         imem_clock      <= ~imem_clock;
         dmem_clock      <= imem_clock;
         processor_clock <= (state_next != STOPPED) && (cnt_next >= HALF);
         core_reset      <= (state_next == HOLD);
         stopped         <= (state_next == STOPPED);
         if (wrap && state == HOLD)
            hold_cnt <= hold_cnt + HW'(1);
         if (wrap && (state == RUN || state == STEP))
            cycle_count <= cycle_count + CNT_W'(1);
         if (state == STOPPED && state_next == STEP)
            step_pending <= 1'b0;
         else if (state == HOLD || state == RUN)
            step_pending <= 1'b0;
         else if (step)
            step_pending <= 1'b1;
      end
   end

   assign regfile_clock = processor_clock;

endmodule

// File: tb/tb_clock_phase_gen.sv
// Bench for clock_phase_gen: period-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_clock_phase_gen;

   localparam int PD = 4;
   localparam int RH = 2;

   logic        clock;
   logic        reset;
   logic        stop_req;
   logic        step;
   logic        imem_clock;
   logic        dmem_clock;
   logic        processor_clock;
   logic        regfile_clock;
   logic        core_reset;
   logic        stopped;
   logic [31:0] cycle_count;

   int vectors = 0;
   int misc    = 0;
   int rises   = 0;
   int n;
   logic [31:0] c0;

   // reference model: edges since release, period flags
   int          m_k      = 0;
   bit          m_hold   = 1'b1;
   int          m_hp     = 0;
   bit          m_halt   = 1'b0;
   bit          m_single = 1'b0;
   bit          m_pend   = 1'b0;
   logic [31:0] m_count  = '0;

   clock_phase_gen #(
      .PROC_DIV   (PD),
      .RESET_HOLD (RH),
      .CNT_W      (32)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .stop_req        (stop_req),
      .step            (step),
      .imem_clock      (imem_clock),
      .dmem_clock      (dmem_clock),
      .processor_clock (processor_clock),
      .regfile_clock   (regfile_clock),
      .core_reset      (core_reset),
      .stopped         (stopped),
      .cycle_count     (cycle_count)
   );

   initial clock = 1'b0;
   always #200 clock = ~clock;

   always @(posedge processor_clock) rises++;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         misc++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick(input int k);
      repeat (k) begin
         @(posedge clock);
         #1;
      end
   endtask

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_k = 0; m_hold = 1'b1; m_hp = 0; m_halt = 1'b0;
         m_single = 1'b0; m_pend = 1'b0; m_count = '0;
      end else begin
         bit at_wrap, free, entered;
         at_wrap = (m_k % PD) == PD - 1;
         free    = m_hold || (!m_halt && !m_single);
         entered = 1'b0;
         if (at_wrap) begin
            if (m_hold) begin
               m_hp++;
               if (m_hp == RH) m_hold = 1'b0;
            end else if (m_halt) begin
               if (m_pend) begin
                  m_halt = 1'b0; m_single = 1'b1; entered = 1'b1;
               end else if (!stop_req) begin
                  m_halt = 1'b0;
               end
            end else begin
               m_count++;
               m_single = 1'b0;
               m_halt   = stop_req;
            end
         end
         if (entered || free) m_pend = 1'b0;
         else if (step)       m_pend = 1'b1;
         m_k++;
      end
   end

   always @(negedge clock) begin
      bit e_proc;
      e_proc = !m_halt && ((m_k % PD) >= PD / 2);
      chk("imem_clock", {31'd0, imem_clock}, (m_k % 2));
      chk("dmem_clock", {31'd0, dmem_clock}, 1 - (m_k % 2));
      chk("processor_clock", {31'd0, processor_clock}, {31'd0, e_proc});
      chk("regfile_clock", {31'd0, regfile_clock}, {31'd0, e_proc});
      chk("core_reset", {31'd0, core_reset}, {31'd0, m_hold});
      chk("stopped", {31'd0, stopped}, {31'd0, m_halt});
      chk("cycle_count", cycle_count, m_count);
   end

   initial begin
      reset = 1'b1; stop_req = 1'b0; step = 1'b0;
      tick(2);
      reset = 1'b0;
      n = 0;
      for (int i = 1; i <= 20 && n == 0; i++) begin
         tick(1);
         if (!core_reset) n = i;
      end
      chk("reset_fall_edges", n, 8);
      chk("hold_proc_rises", rises, 2);
      chk("count_at_release", cycle_count, 0);
      tick(40);
      chk("free_run_count", cycle_count, 10);

      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      for (int i = 0; i < 40 && cycle_count != 5; i++) tick(1);
      chk("reach_count5", cycle_count, 5);
      tick(2);
      stop_req = 1'b1;
      for (int i = 0; i < 8 && !stopped; i++) tick(1);
      chk("stop_count", cycle_count, 6);
      chk("stop_flag", {31'd0, stopped}, 1);
      rises = 0;
      tick(20);
      chk("stop_hold_count", cycle_count, 6);
      chk("stop_no_pulses", rises, 0);

      rises = 0;
      step = 1'b1;
      tick(1);
      step = 1'b0;
      for (int i = 0; i < 12 && stopped; i++) tick(1);
      for (int i = 0; i < 8 && !stopped; i++) tick(1);
      tick(4);
      chk("step_pulses", rises, 1);
      chk("step_count", cycle_count, 7);
      chk("step_restop", {31'd0, stopped}, 1);

      stop_req = 1'b0;
      for (int i = 0; i < 8 && stopped; i++) tick(1);
      c0 = cycle_count;
      step = 1'b1;
      tick(1);
      step = 1'b0;
      tick(7);
      chk("run_step_running", {31'd0, stopped}, 0);

      stop_req = 1'b1;
      for (int i = 0; i < 8 && !stopped; i++) tick(1);
      c0 = cycle_count;
      for (int i = 0; i < 8 && (m_k % PD) != 1; i++) tick(1);
      step = 1'b1; stop_req = 1'b0;
      tick(1);
      step = 1'b0;
      tick(2);
      chk("simul_left_stop", {31'd0, stopped}, 0);
      chk("simul_count0", cycle_count, c0);
      tick(4);
      chk("simul_count1", cycle_count, c0 + 1);
      tick(4);
      chk("simul_count2", cycle_count, c0 + 2);

      stop_req = 1'b1;
      for (int i = 0; i < 8 && !stopped; i++) tick(1);
      for (int i = 0; i < 8 && (m_k % PD) != 1; i++) tick(1);
      step = 1'b1;
      tick(1);
      step = 1'b0;
      tick(4);
      chk("step_high_phase", {31'd0, processor_clock}, 1);
      #50;
      reset = 1'b1;
      #1;
      chk("async_imem", {31'd0, imem_clock}, 0);
      chk("async_dmem", {31'd0, dmem_clock}, 1);
      chk("async_proc", {31'd0, processor_clock}, 0);
      chk("async_regfile", {31'd0, regfile_clock}, 0);
      chk("async_core_reset", {31'd0, core_reset}, 1);
      chk("async_stopped", {31'd0, stopped}, 0);
      chk("async_count", cycle_count, 0);
      stop_req = 1'b0;
      tick(2);
      reset = 1'b0;
      n = 0;
      for (int i = 1; i <= 20 && n == 0; i++) begin
         tick(1);
         if (!core_reset) n = i;
      end
      chk("rerelease_fall_edges", n, 8);
      tick(8);
      chk("rerelease_count", cycle_count, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
      $finish;
   end

endmodule
